// File: rtl/seg_display_sched.sv
// Four-digit common-anode seven-segment scan controller that alternates the display page
// between two 16-bit requesters on frame boundaries.
module seg_display_sched #(
  parameter int unsigned REFRESH_DIV = 4,
  parameter int unsigned PAGE_HOLD   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] src0_data,
  input  logic        src0_valid,
  input  logic [15:0] src1_data,
  input  logic        src1_valid,
  input  logic        freeze,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        page,
  output logic        frame_tick
);

  localparam int unsigned RcW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned FcW = (PAGE_HOLD > 1) ? $clog2(PAGE_HOLD) : 1;
  localparam logic [RcW-1:0] RcMax = RcW'(REFRESH_DIV - 1);
  localparam logic [FcW-1:0] FcMax = FcW'(PAGE_HOLD - 1);

  localparam logic [0:0] SHOW0 = 1'b0;
  localparam logic [0:0] SHOW1 = 1'b1;

  logic [RcW-1:0] rc_q, rc_d;
  logic [1:0]     d_q, d_d;
  logic [FcW-1:0] fc_q, fc_d;
  logic [0:0]     page_q, page_d;
  logic [15:0]    snap_q, snap_d;
  logic           other_valid;
  logic           sel_valid;
  logic [3:0]     nibble;

  function automatic logic [6:0] hex2seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign frame_tick = (rc_q == RcMax) && (d_q == 2'd3);

  always_comb begin
    rc_d   = (rc_q == RcMax) ? '0 : rc_q + RcW'(1);
    d_d    = (rc_q == RcMax) ? d_q + 2'd1 : d_q;
    fc_d   = fc_q;
    page_d = page_q;
    snap_d = snap_q;
    other_valid = (page_q == SHOW0) ? src1_valid : src0_valid;

    if (frame_tick && !freeze) begin
      if (fc_q != FcMax) begin
        fc_d = fc_q + FcW'(1);
      end else begin
        fc_d = '0;
        if (other_valid) page_d = (page_q == SHOW0) ? SHOW1 : SHOW0;
      end
    end

    // Snapshot follows the page chosen on this same boundary.
    sel_valid = (page_d == SHOW0) ? src0_valid : src1_valid;
    if (frame_tick && sel_valid) begin
      snap_d = (page_d == SHOW0) ? src0_data : src1_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rc_q   <= '0;
      d_q    <= '0;
      fc_q   <= '0;
      page_q <= SHOW0;
      snap_q <= '0;
    end else begin
      rc_q   <= rc_d;
      d_q    <= d_d;
      fc_q   <= fc_d;
      page_q <= page_d;
      snap_q <= snap_d;
    end
  end

  always_comb begin
    case (d_q)
      2'd0:    nibble = snap_q[3:0];
      2'd1:    nibble = snap_q[7:4];
      2'd2:    nibble = snap_q[11:8];
      default: nibble = snap_q[15:12];
    endcase
  end

  // Slot 0 of every digit is blanked to avoid ghosting while anodes switch.
  always_comb begin
    if (rc_q == '0) begin
      an  = 4'b1111;
      seg = 7'b1111111;
    end else begin
      an  = ~(4'b0001 << d_q);
      seg = hex2seg(nibble);
    end
  end

  assign page = page_q;

endmodule
